// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and default parameters for the reset/interrupt sequencer
package seq_pkg;
    localparam int DEF_ADDR_W = 8;
    localparam logic [7:0] DEF_RESET_VEC_ADDR = 8'h00;
    localparam logic [7:0] DEF_INTR_VEC_ADDR = 8'h01;
    typedef enum logic [2:0] {IDLE, RST_FETCH, RST_LOAD, INT_FETCH, INT_LOAD} seq_state_t;
endpackage

// File: rtl/intr_edge_latch.sv
// intr_edge_latch: rising-edge detect on intr_req with a sticky pending flag
module intr_edge_latch (
    input  logic clk,
    input  logic rst,
    input  logic intr_req,
    input  logic drop,
    input  logic clr,
    output logic pending
);
    logic intr_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            intr_q  <= 1'b0;
            pending <= 1'b0;
        end else begin
            intr_q  <= intr_req;
            pending <= clr ? 1'b0 : pending | (intr_req & ~intr_q & ~drop);
        end
    end
endmodule

// File: rtl/intr_reset_sequencer.sv
// intr_reset_sequencer: fetches reset/interrupt vectors and sequences PC load pulses
module intr_reset_sequencer
    import seq_pkg::*;
#(
    parameter int                ADDR_W         = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC_ADDR = ADDR_W'(DEF_RESET_VEC_ADDR),
    parameter logic [ADDR_W-1:0] INTR_VEC_ADDR  = ADDR_W'(DEF_INTR_VEC_ADDR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ext_reset_req,
    input  logic              intr_req,
    input  logic              instr_boundary,
    input  logic              rti,
    input  logic [ADDR_W-1:0] pc_current,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_valid,
    input  logic [ADDR_W-1:0] mem_rd_data,
    output logic              RESET_IN,
    output logic              INTR_IN,
    output logic [ADDR_W-1:0] reset_vector,
    output logic [ADDR_W-1:0] intr_vector,
    output logic              stall_req,
    output logic              flush,
    output logic [ADDR_W-1:0] saved_pc,
    output logic              in_isr
);
    seq_state_t state, nxt;
    logic pending, discard, fetch, got, take;
    assign fetch = (state == RST_FETCH) | (state == INT_FETCH);
    // a read abandoned by an external reset still returns once; that response must not be used
    assign got  = mem_rd_valid & ~discard & ~ext_reset_req;
    assign take = (state == IDLE) & pending & ~in_isr & instr_boundary & ~ext_reset_req;

    intr_edge_latch u_edge (
        .clk      (clk),
        .rst      (rst),
        .intr_req (intr_req),
        .drop     ((state == RST_FETCH) | (state == RST_LOAD)),
        .clr      (take | ext_reset_req | (state == RST_LOAD)),
        .pending  (pending)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = take ? INT_FETCH : IDLE;
            RST_FETCH: nxt = got ? RST_LOAD : RST_FETCH;
            RST_LOAD:  nxt = IDLE;
            INT_FETCH: nxt = got ? INT_LOAD : INT_FETCH;
            INT_LOAD:  nxt = IDLE;
            default:   nxt = IDLE;
        endcase
        nxt        = ext_reset_req ? RST_FETCH : nxt;
        mem_rd_req = fetch & ~rst;
        mem_addr   = (state == INT_FETCH) ? INTR_VEC_ADDR : RESET_VEC_ADDR;
        RESET_IN   = (state == RST_LOAD) & ~rst;
        INTR_IN    = (state == INT_LOAD) & ~rst;
        flush      = ((state == RST_LOAD) | (state == INT_LOAD)) & ~rst;
        stall_req  = rst | (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RST_FETCH;
            discard      <= 1'b0;
            in_isr       <= 1'b0;
            saved_pc     <= '0;
            reset_vector <= '0;
            intr_vector  <= '0;
        end else begin
            state   <= nxt;
            discard <= ~mem_rd_valid & (discard | (ext_reset_req & fetch));
            in_isr  <= (ext_reset_req | (state == RST_LOAD)) ? 1'b0 :
                       (state == INT_LOAD) ? 1'b1 :
                       (rti & (state == IDLE)) ? 1'b0 : in_isr;
            if (take) saved_pc <= pc_current;
            if (got & (state == RST_FETCH)) reset_vector <= mem_rd_data;
            if (got & (state == INT_FETCH)) intr_vector <= mem_rd_data;
        end
    end
endmodule

// File: tb/tb_intr_reset_sequencer.sv
// tb_intr_reset_sequencer: scoreboard bench with a variable-latency vector memory model
module tb_intr_reset_sequencer;
    logic clk, rst, ext_reset_req, intr_req, instr_boundary, rti;
    logic [7:0] pc_current, mem_addr, mem_rd_data, reset_vector, intr_vector, saved_pc;
    logic mem_rd_req, mem_rd_valid, RESET_IN, INTR_IN, stall_req, flush, in_isr;

    intr_reset_sequencer dut (
        .clk(clk), .rst(rst), .ext_reset_req(ext_reset_req), .intr_req(intr_req),
        .instr_boundary(instr_boundary), .rti(rti), .pc_current(pc_current),
        .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_rd_valid(mem_rd_valid),
        .mem_rd_data(mem_rd_data), .RESET_IN(RESET_IN), .INTR_IN(INTR_IN),
        .reset_vector(reset_vector), .intr_vector(intr_vector), .stall_req(stall_req),
        .flush(flush), .saved_pc(saved_pc), .in_isr(in_isr)
    );

    typedef struct {logic [1:0] kind; logic [7:0] vec;} exp_t;
    localparam logic [1:0] K_RST = 2'b10;
    localparam logic [1:0] K_INT = 2'b01;
    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int lat = 2;
    logic [7:0] mem [256];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [7:0] vec);
        exp_t e;
        e.kind = kind;
        e.vec  = vec;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sb(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk({tag, "_timeout"}, sb.size(), 0);
    endtask

    task automatic scan_req(input int n, output logic any);
        any = 1'b0;
        repeat (n) begin
            @(negedge clk);
            any |= mem_rd_req;
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // memory: latches the address when a request is accepted, answers lat cycles later
    initial begin
        bit busy;
        int cnt;
        logic [7:0] la;
        busy = 0;
        cnt = 0;
        la = '0;
        mem_rd_valid = 1'b0;
        mem_rd_data = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                busy = 0;
                mem_rd_valid = 1'b0;
            end else begin
                if (mem_rd_valid) begin
                    mem_rd_valid = 1'b0;
                    busy = 0;
                end
                if (busy) begin
                    cnt--;
                    if (cnt == 0) begin
                        mem_rd_valid = 1'b1;
                        mem_rd_data = mem[la];
                    end
                end else if (mem_rd_req) begin
                    busy = 1;
                    la = mem_addr;
                    cnt = lat;
                end
            end
        end
    end

    // scoreboard consumer: every vector pulse must match the next expected event
    initial begin
        logic prev_valid, prev_pulse;
        exp_t e;
        prev_valid = 1'b0;
        prev_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && (RESET_IN || INTR_IN)) begin
                chk("pulse_excl", {31'd0, RESET_IN & INTR_IN}, 0);
                chk("pulse_consec", {31'd0, prev_pulse}, 0);
                chk("pulse_after_valid", {31'd0, prev_valid}, 1);
                chk("flush_with_pulse", {31'd0, flush}, 1);
                if (sb.size() == 0) chk("unexpected_pulse", {30'd0, RESET_IN, INTR_IN}, 0);
                else begin
                    e = sb.pop_front();
                    chk("pulse_kind", {30'd0, RESET_IN, INTR_IN}, {30'd0, e.kind});
                    chk("vector", {24'd0, RESET_IN ? reset_vector : intr_vector}, {24'd0, e.vec});
                end
            end
            prev_valid = mem_rd_valid;
            prev_pulse = RESET_IN | INTR_IN;
        end
    end

    initial begin
        logic any;
        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
        rst = 1'b1;
        ext_reset_req = 1'b0;
        intr_req = 1'b0;
        instr_boundary = 1'b0;
        rti = 1'b0;
        pc_current = '0;
        mem[0] = 8'h20;
        mem[1] = 8'h80;
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'd0, stall_req}, 1);
        chk("rst_req", {31'd0, mem_rd_req}, 0);
        chk("rst_pulses", {29'd0, RESET_IN, INTR_IN, flush}, 0);
        chk("rst_vectors", {16'd0, reset_vector, intr_vector}, 0);
        chk("rst_isr_pc", {23'd0, in_isr, saved_pc}, 0);
        push(K_RST, 8'h20);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("por_fetch", {22'd0, mem_rd_req, stall_req, mem_addr}, {22'd0, 2'b11, 8'h00});
        wait_sb("por", 30);
        @(negedge clk);
        chk("por_stall_drop", {31'd0, stall_req}, 0);

        // interrupt entry
        tick();
        pc_current = 8'h34;
        instr_boundary = 1'b1;
        intr_req = 1'b1;
        push(K_INT, 8'h80);
        @(negedge clk);
        chk("ent_no_req0", {31'd0, mem_rd_req}, 0);
        @(negedge clk);
        chk("ent_no_req1", {31'd0, mem_rd_req}, 0);
        @(negedge clk);
        chk("ent_fetch", {23'd0, mem_rd_req, mem_addr}, {23'd0, 1'b1, 8'h01});
        wait_sb("entry", 30);
        @(negedge clk);
        chk("ent_saved_pc", {24'd0, saved_pc}, 32'h34);
        chk("ent_in_isr", {31'd0, in_isr}, 1);

        // nested request while in ISR stays pending until rti
        tick();
        intr_req = 1'b0;
        tick();
        intr_req = 1'b1;
        scan_req(6, any);
        chk("nest_no_fetch", {31'd0, any}, 0);
        chk("nest_pending", {31'd0, dut.pending}, 1);
        mem[1] = 8'h90;
        pc_current = 8'h56;
        push(K_INT, 8'h90);
        tick();
        rti = 1'b1;
        tick();
        rti = 1'b0;
        @(negedge clk);
        chk("nest_isr_clr", {30'd0, in_isr, mem_rd_req}, 0);
        @(negedge clk);
        chk("nest_reenter", {23'd0, mem_rd_req, mem_addr}, {23'd0, 1'b1, 8'h01});
        wait_sb("nested", 30);
        chk("nest_saved_pc", {24'd0, saved_pc}, 32'h56);
        tick();
        rti = 1'b1;
        tick();
        rti = 1'b0;
        @(negedge clk);
        chk("rti_clear", {31'd0, in_isr}, 0);

        // boundary gating
        tick();
        intr_req = 1'b0;
        instr_boundary = 1'b0;
        tick();
        intr_req = 1'b1;
        scan_req(5, any);
        chk("gate_no_req", {31'd0, any}, 0);
        mem[1] = 8'hA5;
        pc_current = 8'h78;
        push(K_INT, 8'hA5);
        tick();
        instr_boundary = 1'b1;
        @(negedge clk);
        chk("gate_first", {31'd0, mem_rd_req}, 0);
        @(negedge clk);
        chk("gate_fetch", {31'd0, mem_rd_req}, 1);
        wait_sb("gate", 30);
        chk("gate_saved_pc", {24'd0, saved_pc}, 32'h78);
        tick();
        rti = 1'b1;
        tick();
        rti = 1'b0;

        // external reset aborts an interrupt fetch; late read data must be discarded
        lat = 4;
        mem[0] = 8'h3C;
        mem[1] = 8'h99;
        tick();
        intr_req = 1'b0;
        tick();
        intr_req = 1'b1;
        any = 1'b0;
        for (int i = 0; i < 10 && !any; i++) begin
            @(negedge clk);
            any = mem_rd_req;
        end
        chk("abort_int_fetch", {31'd0, any}, 1);
        push(K_RST, 8'h3C);
        tick();
        ext_reset_req = 1'b1;
        tick();
        ext_reset_req = 1'b0;
        @(negedge clk);
        chk("abort_rst_fetch", {22'd0, mem_rd_req, in_isr, mem_addr}, {22'd0, 2'b10, 8'h00});
        wait_sb("abort", 40);
        chk("abort_clean", {30'd0, dut.pending, in_isr}, 0);
        lat = 2;

        // reset and interrupt edge in the same cycle: reset wins, pending cleared
        tick();
        intr_req = 1'b0;
        tick();
        intr_req = 1'b1;
        ext_reset_req = 1'b1;
        push(K_RST, 8'h3C);
        tick();
        ext_reset_req = 1'b0;
        wait_sb("simul", 30);
        @(negedge clk);
        chk("simul_pending", {31'd0, dut.pending}, 0);
        scan_req(4, any);
        chk("simul_no_int", {31'd0, any}, 0);

        // rti outside an ISR changes nothing
        tick();
        rti = 1'b1;
        tick();
        rti = 1'b0;
        @(negedge clk);
        chk("rti_idle", {29'd0, stall_req, in_isr, mem_rd_req}, 0);
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/intr_reset_sequencer.md
Name: intr_reset_sequencer

Overview:
- Generates the RESET_IN/INTR_IN pulses and reset/interrupt vectors consumed by the program counter.
- Handles power-on reset, external reset requests and interrupt entry/exit.
- Fetches vectors from data memory word 0 (reset) and word 1 (interrupt) over a simple read handshake.
- Stalls/flushes the pipeline during a sequence and saves the return PC for the ISR.

Parameters:
- ADDR_W, 8, address/PC/vector width
- RESET_VEC_ADDR, 8'h00, memory address of the reset vector
- INTR_VEC_ADDR, 8'h01, memory address of the interrupt vector

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ext_reset_req  in  1  external reset request (level, sampled each cycle)
- intr_req  in  1  interrupt request line (rising edge detected)
- instr_boundary  in  1  pipeline at instruction boundary; interrupt may be taken
- rti  in  1  return-from-interrupt executed (1-cycle pulse)
- pc_current  in  ADDR_W  PC of next instruction to execute (return address)
- mem_rd_req  out  1  vector read request, held until mem_rd_valid
- mem_addr  out  ADDR_W  vector read address
- mem_rd_valid  in  1  read data valid (1 cycle, latency >=1)
- mem_rd_data  in  ADDR_W  read data
- RESET_IN  out  1  1-cycle pulse: PC loads reset_vector
- INTR_IN  out  1  1-cycle pulse: PC loads intr_vector
- reset_vector  out  ADDR_W  registered reset vector
- intr_vector  out  ADDR_W  registered interrupt vector
- stall_req  out  1  freeze fetch (pc_write gated) during a sequence
- flush  out  1  1-cycle pulse with RESET_IN/INTR_IN; kills in-flight instructions
- saved_pc  out  ADDR_W  return address captured at interrupt entry
- in_isr  out  1  interrupt service in progress (further interrupts masked)

Behaviour:
- Reset:
  - rst=1 forces state RST_FETCH; clears intr_pending, in_isr and saved_pc.
  - Drives RESET_IN=0, INTR_IN=0, flush=0, mem_rd_req=0 and stall_req=1.
  - reset_vector and intr_vector = 0.
  - On rst release, the power-on reset sequence starts automatically.
- States:
  - IDLE
  - RST_FETCH / RST_LOAD
  - INT_FETCH / INT_LOAD
- RST_FETCH:
  - Drives mem_rd_req=1, mem_addr=RESET_VEC_ADDR, stall_req=1.
  - On mem_rd_valid: reset_vector<=mem_rd_data, go to RST_LOAD.
- RST_LOAD (1 cycle):
  - RESET_IN=1, flush=1, stall_req=1.
  - Clears in_isr and intr_pending; next state IDLE.
- Interrupt detection:
  - The edge detector registers intr_req.
  - A rising edge sets intr_pending in any state except RST_*; an edge is dropped while RST_* is active.
  - intr_pending stays set until taken.
- Interrupt entry, from IDLE:
  - Condition: intr_pending & !in_isr & instr_boundary & !ext_reset_req.
  - Action: saved_pc<=pc_current, clear intr_pending, go to INT_FETCH.
- INT_FETCH:
  - Drives mem_rd_req=1, mem_addr=INTR_VEC_ADDR, stall_req=1.
  - On mem_rd_valid: intr_vector<=mem_rd_data, go to INT_LOAD.
- INT_LOAD (1 cycle):
  - INTR_IN=1, flush=1, in_isr<=1; next state IDLE.
- rti:
  - In IDLE with in_isr=1: clear in_isr.
  - Any other time: ignored.
  - A pending interrupt is taken no earlier than the cycle after in_isr clears.
- Priority:
  - ext_reset_req=1 in any state, next cycle → RST_FETCH.
  - This aborts any INT_* sequence mid-fetch; in-flight read data is discarded; intr_pending and in_isr are cleared.
  - Reset beats a simultaneous interrupt.
- Pulse exclusivity: RESET_IN and INTR_IN are never high together and never high more than 1 consecutive cycle.
- stall_req is 0 only in IDLE.
- Latency:
  - Vector pulse occurs 1 cycle after mem_rd_valid.
  - Interrupt entry: boundary → INT_FETCH the next cycle.
- Vectors wrap naturally at ADDR_W bits; no arithmetic is performed.

Decomposition:
- Shared package seq_pkg holds:
  - the state enum (IDLE, RST_FETCH, RST_LOAD, INT_FETCH, INT_LOAD)
  - the RESET_VEC_ADDR/INTR_VEC_ADDR defaults
  - ADDR_W
- One natural sub-module: intr_edge_latch (edge detect plus pending flag with set/clear/drop inputs).

Test Plan:
- Power-on:
  - Stimulus: rst 3 cycles, mem[0]=8'h20, read latency 2.
  - Required: mem_rd_req with addr 00; RESET_IN pulse 1 cycle after valid; reset_vector=20; flush=1 that cycle; stall_req drops the next cycle.
- Interrupt entry:
  - Stimulus: intr_req rise, pc_current=8'h34, instr_boundary=1, mem[1]=8'h80.
  - Required: saved_pc=34; INTR_IN pulse with intr_vector=80; in_isr=1.
- Nested request:
  - Stimulus: second intr_req edge while in_isr=1.
  - Required: no fetch; pending held; after rti, in_isr=0 and the interrupt is re-entered ≥1 cycle later.
- Boundary gating:
  - Stimulus: intr pending with instr_boundary=0 for 5 cycles.
  - Required: no mem_rd_req; entry occurs on the first cycle with boundary=1.
- Abort:
  - Stimulus: ext_reset_req asserted during INT_FETCH before valid.
  - Required: late valid ignored; RST_FETCH addr 00; RESET_IN only; INTR_IN never pulses; in_isr=0.
- Simultaneous events:
  - Stimulus: ext_reset_req and an intr_req edge in the same cycle; separately, rti outside ISR.
  - Required: reset sequence only and pending cleared; rti causes no state change.
